// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - opcode enum, default widths and record layouts for the fpu dispatcher
package fpu_pkg;

   localparam int FP_EXP_W  = 8;
   localparam int FP_MAN_W  = 23;
   localparam int FP_WORD_W = FP_EXP_W + FP_MAN_W + 1;
   localparam int FP_OP_W   = 3;

   typedef enum logic [FP_OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_DIV = 3'b011
   } fpu_op_e;

   // Command record as queued ahead of the fpu (default word width)
   typedef struct packed {
      logic [FP_WORD_W-1:0] a;
      logic [FP_WORD_W-1:0] b;
      fpu_op_e              op;
   } cmd_t;

   // Response record as queued behind the fpu (default word width)
   typedef struct packed {
      logic [FP_WORD_W-1:0] result;
      logic                 exception;
      fpu_op_e              op;
   } rsp_t;

endpackage

// File: rtl/fpu_sync_fifo.sv
// rtl/fpu_sync_fifo.sv - synchronous FIFO with first-word-fall-through read
module fpu_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       push_data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       pop_data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_en, rd_en;

   // Pushes into a full FIFO and pops from an empty one are ignored
   assign wr_en      = push_i && !full_o;
   assign rd_en      = pop_i && !empty_o;
   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign count_o    = count_q;
   assign pop_data_o = mem_q[rd_ptr_q];

   // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap freely
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless while empty so it carries no reset
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/fpu_op_dispatch.sv
// rtl/fpu_op_dispatch.sv - credit-limited in-order command issue and response capture for the fpu (option: FPU_DISPATCH_EXC_STICKY_EN)
module fpu_op_dispatch
   import fpu_pkg::*;
#(
   parameter int EXPONENT_WIDTH = 8,
   parameter int MANTISSA_WIDTH = 23,
   parameter int DEPTH          = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                cmd_valid,
   output logic                                cmd_ready,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] cmd_a,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] cmd_b,
   input  logic [2:0]                          cmd_op,
   output logic                                fpu_valid_in,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] fpu_operand_a,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] fpu_operand_b,
   output logic [2:0]                          fpu_operation,
   input  logic                                fpu_valid_out,
   input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] fpu_result,
   input  logic                                fpu_exception,
   output logic                                rsp_valid,
   input  logic                                rsp_ready,
   output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] rsp_result,
   output logic                                rsp_exception,
   output logic [2:0]                          rsp_op,
   output logic                                busy,
`ifdef FPU_DISPATCH_EXC_STICKY_EN
   input  logic                                exc_clear,
   output logic                                exc_sticky,
`endif
   output logic                                proto_err
);

   localparam int W     = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int CMD_W = 2*W + FP_OP_W;
   localparam int RSP_W = W + 1 + FP_OP_W;

   logic [CMD_W-1:0]   cmd_head;
   logic               cmd_full, cmd_empty, cmd_push;
   logic [CW-1:0]      cmd_count, tag_count, rsp_count, credits;
   logic [FP_OP_W-1:0] tag_head;
   logic               tag_full, tag_empty;
   logic [RSP_W-1:0]   rsp_head;
   logic               rsp_full, rsp_empty, rsp_pop;
   logic               issue, capture;
   logic               unused_fifo;

   logic               fpu_valid_q, fpu_valid_d;
   logic [W-1:0]       fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
   logic [FP_OP_W-1:0] fpu_op_q, fpu_op_d;
   logic               proto_err_q, proto_err_d;

   // The tag FIFO occupancy is the in-flight count; every in-flight op and every
   // queued response holds one credit, so neither downstream FIFO can overflow.
   assign credits   = CW'(DEPTH) - tag_count - rsp_count;
   assign issue     = !cmd_empty && (credits != '0);
   assign capture   = fpu_valid_out && !tag_empty;
   assign cmd_ready = !rst && !cmd_full;
   assign cmd_push  = cmd_valid && cmd_ready;
   assign rsp_valid = !rst && !rsp_empty;
   assign rsp_pop   = rsp_valid && rsp_ready;
   assign busy      = !rst && (!cmd_empty || !tag_empty || !rsp_empty);

   // Response fields read as zero whenever nothing is being offered
   assign {rsp_result, rsp_exception, rsp_op} = rsp_valid ? rsp_head : '0;

   assign fpu_valid_in  = fpu_valid_q;
   assign fpu_operand_a = fpu_a_q;
   assign fpu_operand_b = fpu_b_q;
   assign fpu_operation = fpu_op_q;
   assign proto_err     = proto_err_q;

   assign unused_fifo = ^{cmd_count, tag_full, rsp_full};

   fpu_sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
      .clk(clk), .rst(rst),
      .push_i(cmd_push), .push_data_i({cmd_a, cmd_b, cmd_op}),
      .pop_i(issue), .pop_data_o(cmd_head),
      .full_o(cmd_full), .empty_o(cmd_empty), .count_o(cmd_count)
   );

   fpu_sync_fifo #(.WIDTH(FP_OP_W), .DEPTH(DEPTH)) u_tag_fifo (
      .clk(clk), .rst(rst),
      .push_i(issue), .push_data_i(cmd_head[FP_OP_W-1:0]),
      .pop_i(capture), .pop_data_o(tag_head),
      .full_o(tag_full), .empty_o(tag_empty), .count_o(tag_count)
   );

   fpu_sync_fifo #(.WIDTH(RSP_W), .DEPTH(DEPTH)) u_rsp_fifo (
      .clk(clk), .rst(rst),
      .push_i(capture), .push_data_i({fpu_result, fpu_exception, tag_head}),
      .pop_i(rsp_pop), .pop_data_o(rsp_head),
      .full_o(rsp_full), .empty_o(rsp_empty), .count_o(rsp_count)
   );

   // Issue registers load the queue head on issue and otherwise hold the last op
   always_comb begin
      fpu_valid_d = issue;
      fpu_a_d     = fpu_a_q;
      fpu_b_d     = fpu_b_q;
      fpu_op_d    = fpu_op_q;
      if (issue) {fpu_a_d, fpu_b_d, fpu_op_d} = cmd_head;
      proto_err_d = fpu_valid_out && tag_empty;
   end

   // Issue strobe, operand and protocol-error registers
   always_ff @(posedge clk) begin
      if (rst) begin
         fpu_valid_q <= 1'b0;
         fpu_a_q     <= '0;
         fpu_b_q     <= '0;
         fpu_op_q    <= '0;
         proto_err_q <= 1'b0;
      end else begin
         fpu_valid_q <= fpu_valid_d;
         fpu_a_q     <= fpu_a_d;
         fpu_b_q     <= fpu_b_d;
         fpu_op_q    <= fpu_op_d;
         proto_err_q <= proto_err_d;
      end
   end

`ifdef FPU_DISPATCH_EXC_STICKY_EN
   logic exc_sticky_q, exc_sticky_d;

   // Sticky exception: a delivered exception takes priority over a clear
   always_comb begin
      exc_sticky_d = exc_sticky_q;
      if (exc_clear) exc_sticky_d = 1'b0;
      if (rsp_pop && rsp_exception) exc_sticky_d = 1'b1;
   end

   // Sticky exception register
   always_ff @(posedge clk) begin
      if (rst) exc_sticky_q <= 1'b0;
      else     exc_sticky_q <= exc_sticky_d;
   end

   assign exc_sticky = exc_sticky_q;
`endif

endmodule

// File: tb/tb_fpu_op_dispatch.sv
// tb/tb_fpu_op_dispatch.sv - scoreboard bench for fpu_op_dispatch with a two-cycle fpu model
module tb_fpu_op_dispatch;
   import fpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [31:0] cmd_a, cmd_b;
   logic [2:0]  cmd_op;
   logic        fpu_valid_in;
   logic [31:0] fpu_operand_a, fpu_operand_b;
   logic [2:0]  fpu_operation;
   logic        fpu_valid_out;
   logic [31:0] fpu_result;
   logic        fpu_exception;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_result;
   logic        rsp_exception;
   logic [2:0]  rsp_op;
   logic        busy, proto_err;
`ifdef FPU_DISPATCH_EXC_STICKY_EN
   logic        exc_clear, exc_sticky;
`endif

   fpu_op_dispatch #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .fpu_valid_in(fpu_valid_in), .fpu_operand_a(fpu_operand_a),
      .fpu_operand_b(fpu_operand_b), .fpu_operation(fpu_operation),
      .fpu_valid_out(fpu_valid_out), .fpu_result(fpu_result), .fpu_exception(fpu_exception),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_exception(rsp_exception), .rsp_op(rsp_op),
      .busy(busy),
`ifdef FPU_DISPATCH_EXC_STICKY_EN
      .exc_clear(exc_clear), .exc_sticky(exc_sticky),
`endif
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_issued = 0;
   int n_rsp    = 0;
   cmd_t iss_q[$];
   rsp_t exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference fpu behaviour: {exception, result}
   function automatic logic [32:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
      if (op == OP_ADD && a == 32'h3F800000 && b == 32'h3F800000) return {1'b0, 32'h40000000};
      if (op == OP_MUL && a == 32'h40000000 && b == 32'h40000000) return {1'b0, 32'h40800000};
      if (op == OP_DIV && b == 32'h0) return {1'b1, 32'h7F800000};
      return {1'b0, a ^ {b[28:0], op}};
   endfunction

   // Fpu model: two-cycle pipeline driven on the falling edge, flushed by rst
   logic        s1_v = 1'b0, s2_v = 1'b0, spur_req = 1'b0;
   logic [32:0] s1_r = '0, s2_r = '0;
   initial begin
      fpu_valid_out = 1'b0;
      fpu_result    = '0;
      fpu_exception = 1'b0;
   end
   always @(negedge clk) begin
      if (rst) begin
         s1_v = 1'b0; s2_v = 1'b0; spur_req = 1'b0;
         fpu_valid_out = 1'b0;
      end else begin
         fpu_valid_out = s2_v || spur_req;
         fpu_result    = s2_r[31:0];
         fpu_exception = s2_r[32];
         spur_req = 1'b0;
         s2_v = s1_v;
         s2_r = s1_r;
         s1_v = fpu_valid_in;
         s1_r = fpu_model(fpu_operand_a, fpu_operand_b, fpu_operation);
      end
   end

   // Monitor: checks issued operands and delivered responses against the queues
   cmd_t        iss_e;
   rsp_t        rsp_e;
   logic        prev_stall = 1'b0;
   logic [35:0] prev_rsp = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (fpu_valid_in) begin
            n_issued++;
            if (iss_q.size() == 0) check("issue_unexpected", 1, 0);
            else begin
               iss_e = iss_q.pop_front();
               check("issue_a", fpu_operand_a, iss_e.a);
               check("issue_b", fpu_operand_b, iss_e.b);
               check("issue_op", fpu_operation, iss_e.op);
            end
         end
         if (prev_stall)
            check("rsp_stable", {rsp_valid, rsp_result, rsp_exception, rsp_op}, {1'b1, prev_rsp});
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else begin
               rsp_e = exp_q.pop_front();
               check("rsp_word", {rsp_result, rsp_exception, rsp_op}, rsp_e);
            end
         end
         prev_stall = rsp_valid && !rsp_ready;
         prev_rsp   = {rsp_result, rsp_exception, rsp_op};
      end
   end

   // Optional random back-pressure on the response port
   bit rdy_rand = 1'b0;
   initial forever begin
      @(posedge clk); #1;
      if (rdy_rand) rsp_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drive one command from posedge+1; returns at posedge+1 after the handshake edge
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
      int t = 0;
      logic [32:0] m;
      cmd_t c;
      rsp_t r;
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
      @(negedge clk);
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
      else begin
         m = fpu_model(a, b, op);
         c.a = a; c.b = b; c.op = fpu_op_e'(op);
         r.result = m[31:0]; r.exception = m[32]; r.op = fpu_op_e'(op);
         iss_q.push_back(c);
         exp_q.push_back(r);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      @(negedge clk);
      while (busy && t < 500) begin
         @(negedge clk);
         t++;
      end
      check(tag, busy, 0);
      @(posedge clk); #1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int base_i, base_r, t;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
`ifdef FPU_DISPATCH_EXC_STICKY_EN
      exc_clear = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_outputs", {rsp_valid, busy, fpu_valid_in, proto_err, rsp_result, rsp_op}, 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("post_rst_cmd_ready", cmd_ready, 1);
      check("post_rst_outputs", {rsp_valid, busy, fpu_valid_in, proto_err}, 0);

      // 1: single ADD, minimum latency and single-cycle strobe
      @(posedge clk); #1; rsp_ready = 1'b1;
      base_r = n_rsp;
      send(32'h3F800000, 32'h3F800000, OP_ADD);
      check("t1_no_bypass", fpu_valid_in, 0);
      check("t1_busy", busy, 1);
      @(posedge clk); #1;
      check("t1_issue", fpu_valid_in, 1);
      @(posedge clk); #1;
      check("t1_single_strobe", fpu_valid_in, 0);
      check("t1_hold_a", fpu_operand_a, 32'h3F800000);
      wait_idle("t1_idle");
      check("t1_rsp_count", n_rsp - base_r, 1);

      // 2: back-to-back MUL then ADD, responses in order
      base_r = n_rsp;
      send(32'h40000000, 32'h40000000, OP_MUL);
      send(32'h3F800000, 32'h3F800000, OP_ADD);
      wait_idle("t2_idle");
      check("t2_rsp_count", n_rsp - base_r, 2);

      // Random stream under random back-pressure, including a divide by zero
      base_r = n_rsp;
      rdy_rand = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 5) send(32'h3F800000, 32'h0, OP_DIV);
         else send($urandom, $urandom, 3'($urandom_range(0, 3)));
      end
      wait_idle("rand_idle");
      rdy_rand = 1'b0; rsp_ready = 1'b1;
      check("rand_rsp_count", n_rsp - base_r, 12);

      // 3: stalled responses, credits stop issue at DEPTH and the cmd FIFO fills
      @(posedge clk); #1; rsp_ready = 1'b0;
      base_i = n_issued; base_r = n_rsp;
      for (int i = 0; i < 8; i++) send(32'h1000 + 32'(i), 32'h20 + 32'(i), 3'(i % 4));
      check("t3_cmd_full", cmd_ready, 0);
      idle_cycles(10);
      check("t3_issue_limit", n_issued - base_i, 4);
      check("t3_still_full", cmd_ready, 0);
      check("t3_rsp_valid", rsp_valid, 1);
      rsp_ready = 1'b1;
      wait_idle("t3_idle");
      check("t3_issue_all", n_issued - base_i, 8);
      check("t3_rsp_all", n_rsp - base_r, 8);

      // 4: spurious fpu result with nothing in flight
      spur_req = 1'b1;
      @(posedge clk); #1;
      check("t4_proto_err", proto_err, 1);
      check("t4_no_rsp", rsp_valid, 0);
      @(posedge clk); #1;
      check("t4_proto_pulse", proto_err, 0);
      check("t4_idle", {rsp_valid, busy}, 0);

      // 5: reset with two ops in flight and one response pending
      rsp_ready = 1'b0;
      send(32'h3F800000, 32'h3F800000, OP_ADD);
      t = 0;
      @(negedge clk);
      while (!rsp_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("t5_rsp_pending", rsp_valid, 1);
      @(posedge clk); #1;
      send(32'h11111111, 32'h22222222, OP_SUB);
      send(32'h33333333, 32'h44444444, OP_MUL);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1;
      iss_q.delete(); exp_q.delete();
      check("t5_rst_cmd_ready", cmd_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      check("t5_cleared", {rsp_valid, busy, fpu_valid_in}, 0);
      check("t5_cmd_ready", cmd_ready, 1);
`ifdef FPU_DISPATCH_EXC_STICKY_EN
      check("t5_sticky_rst", exc_sticky, 0);
`endif
      @(posedge clk); #1;
      base_i = n_issued; base_r = n_rsp;
      for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), 32'hB0, OP_ADD);
      idle_cycles(10);
      check("t5_credits_full", n_issued - base_i, 4);
      send(32'hC0, 32'hD0, OP_SUB);
      idle_cycles(6);
      check("t5_credits_stop", n_issued - base_i, 4);
      check("t5_no_stale_rsp", n_rsp - base_r, 0);
      rsp_ready = 1'b1;
      wait_idle("t5_idle");
      check("t5_rsp_all", n_rsp - base_r, 5);

`ifdef FPU_DISPATCH_EXC_STICKY_EN
      // 6: sticky exception holds until cleared
      send(32'h3F800000, 32'h0, OP_DIV);
      wait_idle("t6_idle");
      check("t6_sticky_set", exc_sticky, 1);
      send(32'h3F800000, 32'h3F800000, OP_ADD);
      wait_idle("t6_idle2");
      check("t6_sticky_hold", exc_sticky, 1);
      exc_clear = 1'b1;
      @(posedge clk); #1; exc_clear = 1'b0;
      check("t6_sticky_clear", exc_sticky, 0);
`endif

      check("sb_exp_empty", exp_q.size(), 0);
      check("sb_iss_empty", iss_q.size(), 0);
      check("final_busy", busy, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
